// File: rtl/onehot_sel_pkg.sv
// Shared encodings for the one-hot selector sequencer.
package onehot_sel_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_sel_seq_dec.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder.
module onehot_dec #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      idx_i,
  output logic [2**SEL_W-1:0]   onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/onehot_sel_seq.sv
// Registered one-hot strobe generator with decode / scan-up / scan-down / hold sequencing.
module onehot_sel_seq
  import onehot_sel_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [SEL_W-1:0]    sel,
  input  logic                step,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                valid,
  output logic                wrap
);

  localparam int              OUT_W   = 2**SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  state_e             st_q, st_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   dec_out;
  logic               at_end;

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx_i    (idx_d),
    .onehot_o (dec_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      idx_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    at_end = 1'b0;
    unique case (mode_e'(mode))
      MODE_DECODE: begin
        if (load || en) begin
          idx_d = sel;
          st_d  = ST_ACTIVE;
        end
      end
      MODE_SCAN_UP, MODE_SCAN_DOWN: begin
        // End detection happens on the current index, before any increment.
        at_end = (mode_e'(mode) == MODE_SCAN_UP) ? (idx_q == IDX_MAX) : (idx_q == '0);
        if (load) begin
          idx_d = sel;
          st_d  = ST_ACTIVE;
        end else if (step && st_q == ST_ACTIVE) begin
          if (at_end) begin
            wrap_d = 1'b1;
            if (WRAP_EN) idx_d = (mode_e'(mode) == MODE_SCAN_UP) ? '0 : IDX_MAX;
            else         st_d  = ST_IDLE;
          end else begin
            idx_d = (mode_e'(mode) == MODE_SCAN_UP) ? idx_q + SEL_W'(1) : idx_q - SEL_W'(1);
          end
        end
      end
      default: ;
    endcase
    out_d = (en && st_d == ST_ACTIVE) ? dec_out : '0;
  end

  assign out   = out_q;
  assign idx   = idx_q;
  assign valid = (st_q == ST_ACTIVE);
  assign wrap  = wrap_q;

endmodule

// File: doc/onehot_sel_seq.md
Name: onehot_sel_seq

Overview:
- Parametrised, registered successor to the fixed 4-to-16 one-hot demux.
- Converts a SEL_W-bit index into a 2**SEL_W one-hot strobe.
- Adds load/step sequencing: direct decode, scan up, scan down and hold modes, with wrap detection.
- Drives register-file write strobes in normal operation and register-scan/dump sequencing for debug.

Parameters:
- SEL_W, 4, index width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- WRAP_EN, 1, 1 = scan wraps at the ends; 0 = scan terminates at the end (valid drops).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  output gate; 0 forces out to zero on the next edge, state retained.
- mode  input  2  00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
- load  input  1  capture sel into idx.
- sel  input  SEL_W  index to load or decode.
- step  input  1  advance idx in scan modes.
- out  output  OUT_W  registered one-hot strobe, bit idx set.
- idx  output  SEL_W  current registered index.
- valid  output  1  idx holds a live selection.
- wrap  output  1  one-cycle pulse on a wrap, or on scan termination.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-low.
  - rst_n=0 at an edge forces out=0, idx=0, valid=0, wrap=0 and state=IDLE, overriding all other inputs.
  - Reset asserted mid-scan aborts the scan cleanly; there is no partial state.
- States: IDLE (valid=0) and ACTIVE (valid=1).
- Output register:
  - out is registered. At each edge: out <= (en && next_valid) ? onehot(next_idx) : 0.
  - Latency from load/step to out is 1 cycle; idx and valid update on the same edge.
- Priority per edge: reset > load > step > hold.
- load=1, any mode except HOLD: idx <= sel, valid <= 1, go to ACTIVE.
- DECODE mode:
  - While en=1, idx <= sel every cycle, so load is implied; valid <= 1.
  - step is ignored.
- SCAN_UP, step=1, ACTIVE:
  - idx < OUT_W-1: idx <= idx+1.
  - idx = OUT_W-1, WRAP_EN=1: idx <= 0 and wrap pulses.
  - idx = OUT_W-1, WRAP_EN=0: valid <= 0, go to IDLE, wrap pulses, idx holds OUT_W-1.
- SCAN_DOWN: mirror of SCAN_UP; the end is idx = 0 and wrapping goes to OUT_W-1.
- step in IDLE: ignored, no wrap.
- HOLD: load and step are both ignored; idx and valid are frozen; out still honours en.
- load and step in the same cycle: load wins and idx <= sel, with no increment and no wrap, even if sel is at an end.
- wrap is high for exactly one cycle per wrap/termination event, and is 0 otherwise.
- mode may change on any cycle and takes effect on the same edge; idx is preserved across mode changes.
- en=0 does not stop sequencing: idx and valid still advance, only out is gated.
- Arithmetic: idx arithmetic is modulo 2**SEL_W, with end detection done before increment. There are no X/undefined states; an out value with more than one bit set is illegal.

Decomposition:
- Shared package onehot_sel_pkg:
  - Mode encodings MODE_DECODE=2'b00, MODE_SCAN_UP=2'b01, MODE_SCAN_DOWN=2'b10, MODE_HOLD=2'b11.
  - State encodings ST_IDLE and ST_ACTIVE.
- One natural sub-module: onehot_dec, a purely combinational SEL_W -> 2**SEL_W decoder.
  - Parametrised generalisation of the existing demux; instantiated once, feeding the out register.

Test Plan:
- Reset/decode (SEL_W=4): rst_n=0 two cycles -> out=0, valid=0, idx=0. Release, mode=DECODE, en=1, sel=4'd9 -> next cycle out=16'h0200, idx=9, valid=1.
- Scan-up wrap (WRAP_EN=1): load sel=14, mode=SCAN_UP, step 3 cycles -> out 16'h4000 -> 16'h8000 -> 16'h0001 -> 16'h0002. wrap is high exactly on the 16'h8000->16'h0001 edge.
- Scan-down terminate (WRAP_EN=0): load sel=1, mode=SCAN_DOWN, step 2 cycles:
  - First step -> idx=0, out=16'h0001.
  - Second step -> valid=0, out=0, wrap pulses once.
  - Further steps -> no change.
- Priority: mode=SCAN_UP, idx=15, load=1 with sel=3 and step=1 in the same cycle -> idx=3, out=16'h0008, wrap=0.
- Gating/hold:
  - en=0 during a scan -> out=0 while idx keeps incrementing 5->6->7; en=1 -> out=16'h0080.
  - mode=HOLD with step and load asserted -> idx frozen.
- Mid-op reset and width: SEL_W=3, scan running at idx=5, rst_n=0 for one cycle -> out=8'h00, idx=0, valid=0. Reload sel=7 -> out=8'h80.
